dp_tpp_sched: RTL and testbench

- Slot scheduler for the dp triple-pingpong datapath.
- Steps a job of N tiles through three stages that overlap: AXI load, NTT, and a post stage.
- The post stage is URAM write-back in ciphertext mode, or MADD in plaintext mode.
- Each slot it starts the active stages and collects their done events. Once every active stage has finished, it pulses a buffer-rotate. It sits above dp_top and drives its start, idx_split and mode inputs.

---
 rtl/dp_tpp_sched_if.sv | 38 +++
 rtl/dp_tpp_sched.sv | 143 ++++++++++++++
 tb/tb_dp_tpp_sched.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_tpp_sched_if.sv
// Control bundle between the triple-pingpong slot scheduler and the dp datapath.
// The scheduler side takes the master modport; the datapath or bench side takes the slave modport.
interface dp_tpp_sched_if #(
    parameter int TILE_W    = 6,
    parameter int LOG_SPLIT = 2
);
    logic                 i_start;
    logic [1:0]           i_mode;
    logic [TILE_W-1:0]    i_num_tiles;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;
    logic [1:0]           o_mode;
    logic                 o_axi_req;
    logic [TILE_W-1:0]    o_axi_tile;
    logic                 i_axi_done;
    logic                 o_ntt_start;
    logic [LOG_SPLIT-1:0] o_ntt_split;
    logic                 i_ntt_done;
    logic                 o_wruram_start;
    logic                 o_madd_start;
    logic [LOG_SPLIT-1:0] o_post_split;
    logic                 i_post_done;
    logic                 o_rotate;
    logic [TILE_W:0]      o_slot;

    modport master (
        input  i_start, i_mode, i_num_tiles, i_axi_done, i_ntt_done, i_post_done,
        output o_busy, o_done, o_err, o_mode, o_axi_req, o_axi_tile, o_ntt_start,
               o_ntt_split, o_wruram_start, o_madd_start, o_post_split, o_rotate, o_slot
    );

    modport slave (
        output i_start, i_mode, i_num_tiles, i_axi_done, i_ntt_done, i_post_done,
        input  o_busy, o_done, o_err, o_mode, o_axi_req, o_axi_tile, o_ntt_start,
               o_ntt_split, o_wruram_start, o_madd_start, o_post_split, o_rotate, o_slot
    );
endinterface

// File: rtl/dp_tpp_sched.sv
// Slot scheduler for the triple-pingpong datapath: overlaps load, NTT and post
// stages over N+2 slots and pulses a buffer rotate once every active stage is done.
module dp_tpp_sched #(
    parameter int NUM_SPLIT = 4,
    parameter int TILE_W    = 6,
    parameter int LOG_SPLIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    dp_tpp_sched_if.master     bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ROTATE, FIN} state_t;

    localparam logic [1:0] MODE_CT = 2'b01;
    localparam logic [1:0] MODE_PT = 2'b10;

    state_t              state_reg, state_next;
    logic [1:0]          mode_reg, mode_next;
    logic [TILE_W-1:0]   num_reg, num_next;
    logic [TILE_W:0]     slot_reg, slot_next;
    logic [2:0]          flag_reg, flag_next;
    logic                err_reg, err_next;

    logic                in_job;
    logic [TILE_W:0]     num_ext;
    logic [TILE_W:0]     last_slot;
    logic [2:0]          active;
    logic [2:0]          done_in;
    logic [2:0]          flag_issue;
    logic [2:0]          flag_wait;
    logic                mode_legal;
    logic                post_go;
    logic [TILE_W:0]     stage_tile  [1:2];
    logic [LOG_SPLIT-1:0] stage_split [1:2];

    function automatic logic [LOG_SPLIT-1:0] split_of(input logic [TILE_W:0] tile);
        return LOG_SPLIT'(tile % (TILE_W+1)'(NUM_SPLIT));
    endfunction

    assign in_job     = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == ROTATE);
    assign num_ext    = {1'b0, num_reg};
    assign last_slot  = num_ext + (TILE_W+1)'(1);
    assign mode_legal = (bus.i_mode == MODE_CT) || (bus.i_mode == MODE_PT);

    // Stage 0 loads tile s, stage 1 transforms tile s-1, stage 2 posts tile s-2.
    assign active[0] = in_job && (slot_reg < num_ext);
    assign active[1] = in_job && (slot_reg >= (TILE_W+1)'(1)) && (slot_reg <= num_ext);
    assign active[2] = in_job && (slot_reg >= (TILE_W+1)'(2)) && (slot_reg <= last_slot);
    assign done_in   = {bus.i_post_done, bus.i_ntt_done, bus.i_axi_done};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            // Inactive stages count as finished for the whole slot.
            assign flag_issue[gi] = ~active[gi];
            assign flag_wait[gi]  = flag_reg[gi] | (active[gi] & done_in[gi]);
        end
        for (genvar gi = 1; gi < 3; gi++) begin : g_split
            assign stage_tile[gi]  = slot_reg - (TILE_W+1)'(gi);
            assign stage_split[gi] = active[gi] ? split_of(stage_tile[gi]) : '0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        num_next   = num_reg;
        slot_next  = slot_reg;
        flag_next  = flag_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_start) begin
                    if (mode_legal) begin
                        mode_next  = bus.i_mode;
                        num_next   = bus.i_num_tiles;
                        slot_next  = '0;
                        flag_next  = '0;
                        state_next = (bus.i_num_tiles == '0) ? FIN : ISSUE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                flag_next  = flag_issue;
                state_next = WAIT;
            end
            WAIT: begin
                flag_next = flag_wait;
                if (&flag_wait) begin
                    state_next = ROTATE;
                end
            end
            ROTATE: begin
                if (slot_reg == last_slot) begin
                    state_next = FIN;
                end else begin
                    slot_next  = slot_reg + (TILE_W+1)'(1);
                    state_next = ISSUE;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= '0;
            num_reg   <= '0;
            slot_reg  <= '0;
            flag_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            num_reg   <= num_next;
            slot_reg  <= slot_next;
            flag_reg  <= flag_next;
            err_reg   <= err_next;
        end
    end

    assign post_go            = (state_reg == ISSUE) && active[2];
    assign bus.o_axi_req      = (state_reg == ISSUE) && active[0];
    assign bus.o_axi_tile     = active[0] ? slot_reg[TILE_W-1:0] : '0;
    assign bus.o_ntt_start    = (state_reg == ISSUE) && active[1];
    assign bus.o_ntt_split    = stage_split[1];
    assign bus.o_wruram_start = post_go && (mode_reg == MODE_CT);
    assign bus.o_madd_start   = post_go && (mode_reg != MODE_CT);
    assign bus.o_post_split   = stage_split[2];
    assign bus.o_rotate       = (state_reg == ROTATE);
    assign bus.o_done         = (state_reg == FIN);
    assign bus.o_busy         = (state_reg != IDLE);
    assign bus.o_err          = err_reg;
    assign bus.o_mode         = mode_reg;
    assign bus.o_slot         = slot_reg;
endmodule

// File: tb/tb_dp_tpp_sched.sv
// Scoreboard bench for dp_tpp_sched: directed jobs push expected output events,
// a monitor compares every cycle in which the scheduler pulses something.
module tb_dp_tpp_sched;
    localparam logic [1:0] R_PULSE = 2'd0;
    localparam logic [1:0] R_LEVEL = 2'd1;
    localparam logic [1:0] R_MAN   = 2'd2;

    typedef struct packed {
        logic       axi_req;
        logic [5:0] axi_tile;
        logic       ntt_start;
        logic [1:0] ntt_split;
        logic       wr;
        logic       madd;
        logic [1:0] post_split;
        logic       rotate;
        logic       done;
        logic       err;
        logic       busy;
        logic [1:0] mode;
        logic [6:0] slot;
    } sig_t;

    typedef struct {
        int   off;
        sig_t s;
    } ev_t;

    logic clk;
    logic rst;
    logic [1:0] resp;
    logic man_a, man_n, man_p;
    logic pa, pn, pp;
    logic snap;
    int   ncyc;
    int   t0;
    int   checks = 0;
    int   errs   = 0;
    ev_t  q[$];

    dp_tpp_sched_if #(.TILE_W(6), .LOG_SPLIT(2)) bus ();

    dp_tpp_sched #(.NUM_SPLIT(4), .TILE_W(6), .LOG_SPLIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_axi_done  = (resp == R_LEVEL) | ((resp == R_PULSE) & pa) | ((resp == R_MAN) & man_a);
    assign bus.i_ntt_done  = (resp == R_LEVEL) | ((resp == R_PULSE) & pn) | ((resp == R_MAN) & man_n);
    assign bus.i_post_done = (resp == R_LEVEL) | ((resp == R_PULSE) & pp) | ((resp == R_MAN) & man_p);

    // Pulse responder: each stage reports done during the cycle after its start.
    initial begin
        logic ca, cn, cp;
        pa = 1'b0; pn = 1'b0; pp = 1'b0;
        forever begin
            @(negedge clk);
            ca = bus.o_axi_req;
            cn = bus.o_ntt_start;
            cp = bus.o_wruram_start | bus.o_madd_start;
            @(posedge clk);
            #1;
            pa = ca; pn = cn; pp = cp;
        end
    end

    function automatic sig_t sample();
        sig_t r;
        r.axi_req    = bus.o_axi_req;
        r.axi_tile   = bus.o_axi_tile;
        r.ntt_start  = bus.o_ntt_start;
        r.ntt_split  = bus.o_ntt_split;
        r.wr         = bus.o_wruram_start;
        r.madd       = bus.o_madd_start;
        r.post_split = bus.o_post_split;
        r.rotate     = bus.o_rotate;
        r.done       = bus.o_done;
        r.err        = bus.o_err;
        r.busy       = bus.o_busy;
        r.mode       = bus.o_mode;
        r.slot       = bus.o_slot;
        return r;
    endfunction

    function automatic string fmt(sig_t r);
        return $sformatf("req=%0d tile=%0d ntt=%0d/%0d wr=%0d madd=%0d post=%0d rot=%0d done=%0d err=%0d busy=%0d mode=%0d slot=%0d",
                         r.axi_req, r.axi_tile, r.ntt_start, r.ntt_split, r.wr, r.madd, r.post_split,
                         r.rotate, r.done, r.err, r.busy, r.mode, r.slot);
    endfunction

    // Monitor / scoreboard: one comparison per output event.
    initial begin
        int   off;
        sig_t got;
        ev_t  e;
        ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc = ncyc + 1;
            off  = ncyc - t0;
            if (q.size() > 0 && q[0].off >= 0 && off > q[0].off) begin
                checks = checks + 1;
                errs   = errs + 1;
                $display("FAIL missing_event: nothing by off=%0d, required off=%0d %s", off, q[0].off, fmt(q[0].s));
                void'(q.pop_front());
            end
            got = sample();
            if (got.axi_req | got.ntt_start | got.wr | got.madd | got.rotate | got.done | got.err | snap) begin
                checks = checks + 1;
                if (q.size() == 0) begin
                    errs = errs + 1;
                    $display("FAIL unexpected_event: off=%0d got %s", off, fmt(got));
                end else begin
                    e = q.pop_front();
                    if (got != e.s || (e.off >= 0 && e.off != off)) begin
                        errs = errs + 1;
                        $display("FAIL event: got off=%0d %s | required off=%0d %s", off, fmt(got), e.off, fmt(e.s));
                    end else begin
                        $display("ev off=%0d %s", off, fmt(got));
                    end
                end
            end
        end
    end

    task automatic push(input int off, input sig_t s);
        ev_t e;
        e.off = off;
        e.s   = s;
        q.push_back(e);
    endtask

    function automatic sig_t mk_slot(int s, int n, logic [1:0] md, bit is_issue);
        sig_t r = '0;
        bit la = (s < n);
        bit na = (s >= 1) && (s <= n);
        bit pv = (s >= 2) && (s <= n + 1);
        r.busy = 1'b1;
        r.mode = md;
        r.slot = 7'(s);
        if (la) r.axi_tile = 6'(s);
        if (na) r.ntt_split = 2'((s - 1) % 4);
        if (pv) r.post_split = 2'((s - 2) % 4);
        if (is_issue) begin
            r.axi_req   = la;
            r.ntt_start = na;
            r.wr        = pv && (md == 2'b01);
            r.madd      = pv && (md != 2'b01);
        end else begin
            r.rotate = 1'b1;
        end
        return r;
    endfunction

    task automatic expect_slot(input int s, input int n, input logic [1:0] md, input int ioff, input int roff);
        push(ioff, mk_slot(s, n, md, 1'b1));
        push(roff, mk_slot(s, n, md, 1'b0));
    endtask

    task automatic expect_done(input int off, input logic [1:0] md, input int slot);
        sig_t r = '0;
        r.done = 1'b1;
        r.busy = 1'b1;
        r.mode = md;
        r.slot = 7'(slot);
        push(off, r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_off(input int k);
        while (ncyc - t0 < k - 1) tick();
    endtask

    task automatic begin_job(input logic [1:0] md, input int n);
        bus.i_start     = 1'b1;
        bus.i_mode      = md;
        bus.i_num_tiles = 6'(n);
        t0              = ncyc;
    endtask

    task automatic end_start();
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 400) begin
            tick();
            b++;
        end
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sig_t z;
        t0 = 0;
        rst = 1'b1; snap = 1'b0; resp = R_PULSE;
        man_a = 1'b0; man_n = 1'b0; man_p = 1'b0;
        bus.i_start = 1'b0; bus.i_mode = 2'b00; bus.i_num_tiles = '0;
        repeat (3) tick();
        rst = 1'b0;
        z = '0;
        snap = 1'b1;
        push(-1, z);
        tick();
        snap = 1'b0;
        tick();

        // Ciphertext, N=1, pulse dones: done at offset 11.
        begin_job(2'b01, 1);
        for (int s = 0; s <= 2; s++) expect_slot(s, 1, 2'b01, 2 + 3 * s, 4 + 3 * s);
        expect_done(11, 2'b01, 2);
        end_start();
        drain();

        // Plaintext, N=5, dones tied high.
        resp = R_LEVEL;
        begin_job(2'b10, 5);
        for (int s = 0; s <= 6; s++) expect_slot(s, 5, 2'b10, 2 + 3 * s, 4 + 3 * s);
        expect_done(23, 2'b10, 6);
        end_start();
        drain();
        resp = R_PULSE;

        // Illegal mode: one error pulse, still idle, latched state unchanged.
        begin_job(2'b11, 3);
        z = '0; z.err = 1'b1; z.mode = 2'b10; z.slot = 7'd6;
        push(2, z);
        end_start();
        drain();

        // Zero tiles: done right after the start, no stage starts.
        begin_job(2'b01, 0);
        expect_done(2, 2'b01, 0);
        end_start();
        drain();

        // N=4, staggered dones in slot 3: rotate follows the late NTT done.
        begin_job(2'b01, 4);
        for (int s = 0; s <= 2; s++) expect_slot(s, 4, 2'b01, 2 + 3 * s, 4 + 3 * s);
        expect_slot(3, 4, 2'b01, 11, 21);
        expect_slot(4, 4, 2'b01, 22, 24);
        expect_slot(5, 4, 2'b01, 25, 27);
        expect_done(28, 2'b01, 5);
        end_start();
        at_off(10); resp  = R_MAN;
        at_off(13); man_a = 1'b1;
        at_off(14); man_a = 1'b0;
        at_off(16); man_p = 1'b1;
        at_off(17); man_p = 1'b0;
        at_off(20); man_n = 1'b1;
        at_off(21); man_n = 1'b0;
        at_off(22); resp  = R_PULSE;
        drain();

        // Reset during WAIT of slot 2, then a fresh job one cycle later.
        begin_job(2'b10, 3);
        expect_slot(0, 3, 2'b10, 2, 4);
        expect_slot(1, 3, 2'b10, 5, 7);
        push(8, mk_slot(2, 3, 2'b10, 1'b1));
        end_start();
        at_off(9);  rst = 1'b1;
        at_off(10); rst = 1'b0;
        z = '0;
        snap = 1'b1;
        push(-1, z);
        at_off(11);
        snap = 1'b0;

        // Done during ISSUE is ignored; a start while busy has no effect.
        begin_job(2'b01, 2);
        expect_slot(0, 2, 2'b01, 2, 4);
        expect_slot(1, 2, 2'b01, 5, 11);
        expect_slot(2, 2, 2'b01, 12, 14);
        expect_slot(3, 2, 2'b01, 15, 17);
        expect_done(18, 2'b01, 3);
        end_start();
        at_off(4); resp  = R_MAN;
        at_off(5); man_n = 1'b1;
        at_off(6); man_n = 1'b0; man_a = 1'b1;
        at_off(7); man_a = 1'b0;
        bus.i_start = 1'b1; bus.i_mode = 2'b10; bus.i_num_tiles = 6'd7;
        at_off(8); bus.i_start = 1'b0;
        at_off(10); man_n = 1'b1;
        at_off(11); man_n = 1'b0;
        at_off(12); resp  = R_PULSE;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
